modaddsub_serial: RTL
=====================

# modaddsub_serial

Parametrised, slice-serial modular adder/subtractor: computes (in_a ± in_b) mod in_m over several cycles, processing SLICE bits per cycle with two concurrent carry chains (raw sum/difference and its modulus-corrected twin). It is the next-generation replacement for the fixed 381-bit two-adder modular add/sub in the ECDSA verify datapath. It trades latency for a short critical path and scales to any field width. Operands are latched on start, and results are held stable until the next accepted start.

## Interface
Parameters:
- WIDTH, 381: operand/modulus width in bits.
- SLICE, 64: bits processed per cycle (1 ≤ SLICE ≤ WIDTH+1).
- NSLICE (localparam), ceil((WIDTH+1)/SLICE): slice count; 6 at defaults.

Ports:
- clk, input, 1: clock, rising edge.
- resetn, input, 1: reset, asynchronous, active-low.
- start, input, 1: request; accepted only when the block is idle.
- subtract, input, 1: 0 = add, 1 = subtract; sampled with start.
- in_a, input, WIDTH: operand A; sampled with start.
- in_b, input, WIDTH: operand B; sampled with start.
- in_m, input, WIDTH: modulus, must be > 0; sampled with start.
- result, output, WIDTH: modular result; held until the next accepted start.
- done, output, 1: single-cycle pulse; result is valid from this cycle onward.
- busy, output, 1: operation in flight.
- range_err, output, 1: operand out of range (see Configuration); updated with done.

## Operation
- States: IDLE, RUN, FIN.
- IDLE, start=1: latch a, b, m and subtract into internal registers. Clear both carry registers: chain1 carry-in = subtract, chain2 carry-in = ~subtract. Slice counter = 0. Go to RUN.
- RUN, each cycle, slice k = counter:
  - chain1: s_k = a_k + (subtract ? ~b_k : b_k) + c1.
  - chain2: t_k = s_k + (subtract ? m_k : ~m_k) + c2.
  - Store s_k and t_k into shift/slice buffers, and update c1 and c2.
  - The top slice is zero-extended above WIDTH.
  - When counter = NSLICE-1, go to FIN.
- FIN:
  - Add (subtract=0): result = (c2 ? t : s)[WIDTH-1:0]. This is s−m when a+b ≥ m, else a+b.
  - Subtract (subtract=1): result = (c1 ? s : t)[WIDTH-1:0]. This is a−b when a ≥ b, else a−b+m.
  - Pulse done and go to IDLE.
- Functional contract for a, b < m: add gives (a+b) mod m; subtract gives (a−b) mod m. Values a, b ≥ m are undefined unless range checking is enabled.
- Start while busy=1 is ignored: no latch, no effect on the current operation.
- Operand inputs may change freely after the start cycle.
- Reset, at any time including mid-RUN, aborts the operation:
  - State returns to IDLE.
  - result=0, done=0, busy=0, range_err=0, and all internal registers are cleared.
  - No done is produced for the aborted operation.

## Timing
- Start accepted at edge T.
- busy=1 from T+1 through T+NSLICE.
- result and done updated at edge T+NSLICE+1. done is high for exactly that one cycle, and busy=0 in that cycle.
- Total latency is NSLICE+1 cycles: 7 at defaults.
- Start asserted in the done cycle is accepted, giving a throughput of one operation per NSLICE+1 cycles.
- result and range_err change only at the done edge or on reset.
- Critical path: one SLICE-bit adder feeding one SLICE-bit adder, plus slice muxing. No full-WIDTH carry path.

## Configuration
- MODADDSUB_RANGECHK_EN defined:
  - A third carry chain computes a−m and b−m per slice in parallel (a fourth chain, or time-shared equivalent, is allowed).
  - At done, range_err=1 if a ≥ m or b ≥ m, and result is forced to 0.
  - Otherwise range_err=0 and result is normal. Latency is unchanged.
- Not defined: range_err is tied to 0, no check logic is generated, and results for out-of-range operands are undefined.

## Test plan
- Defaults, add a=5, b=7, m=11, start at T → done only at T+7, result=1, busy high T+1..T+6.
- Defaults, subtract a=3, b=9, m=11 → result=5. Then subtract a=9, b=3, m=11 → result=6.
- Defaults, m=2^381−1, add a=b=m−1 → result=m−2 (carry ripples through all 6 slices). Subtract a=0, b=1 → result=m−1.
- WIDTH=8, SLICE=3 (NSLICE=3), add a=200, b=100, m=251: start pulsed again while busy → ignored; result=49 at T+4; start asserted in the done cycle with subtract a=0, b=0 → result=0 at T+8.
- Defaults, reset asserted at T+3 of an add → result=0, done=0, busy=0 immediately; no done pulse follows. A new start after reset completes normally.
- MODADDSUB_RANGECHK_EN defined, a=11, b=2, m=11 → done at T+7, range_err=1, result=0. Macro not defined → range_err stays 0.

Source files
------------

// File: rtl/modaddsub_serial.sv
// modaddsub_serial: slice-serial modular adder/subtractor.
// Computes (in_a +/- in_b) mod in_m over NSLICE cycles, SLICE bits per cycle,
// with two carry chains: the raw sum/difference and its modulus-corrected twin.
// Optional operand range check is built when MODADDSUB_RANGECHK_EN is defined;
// otherwise range_err is tied low.
module modaddsub_serial #(
    parameter int unsigned WIDTH = 381,
    parameter int unsigned SLICE = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             range_err
);

    // ceil((WIDTH+1)/SLICE): one guard bit above WIDTH holds the add carry
    localparam int unsigned NSLICE = (WIDTH + SLICE) / SLICE;
    localparam int unsigned TOT    = NSLICE * SLICE;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [TOT-1:0]   a_q, a_d, b_q, b_d, m_q, m_d;
    logic [TOT-1:0]   s_q, s_d, t_q, t_d;
    logic             sub_q, sub_d;
    logic             c1_q, c1_d, c2_q, c2_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;

    // slice datapath signals
    logic [SLICE-1:0] a_k, b_k, m_k, bx, mx, s_k, t_k;
    logic [SLICE:0]   sum1, sum2;
    logic             c1_n, c2_n;
    logic [TOT-1:0]   s_full, t_full, sel_full;
    logic             last;
    logic             unused_hi;

`ifdef MODADDSUB_RANGECHK_EN
    logic             rerr_q, rerr_d;
    logic             c3_q, c3_d, c4_q, c4_d;
    logic [SLICE:0]   sum3, sum4;
    logic             c3_n, c4_n;
`endif

    // one slice of both carry chains, plus the full-width view after this slice
    always_comb begin
        a_k  = a_q[SLICE-1:0];
        b_k  = b_q[SLICE-1:0];
        m_k  = m_q[SLICE-1:0];
        bx   = sub_q ? ~b_k : b_k;
        mx   = sub_q ? m_k : ~m_k;
        sum1 = {1'b0, a_k} + {1'b0, bx} + {{SLICE{1'b0}}, c1_q};
        s_k  = sum1[SLICE-1:0];
        c1_n = sum1[SLICE];
        sum2 = {1'b0, s_k} + {1'b0, mx} + {{SLICE{1'b0}}, c2_q};
        t_k  = sum2[SLICE-1:0];
        c2_n = sum2[SLICE];
`ifdef MODADDSUB_RANGECHK_EN
        // a - m and b - m: carry out set means operand >= modulus
        sum3 = {1'b0, a_k} + {1'b0, ~m_k} + {{SLICE{1'b0}}, c3_q};
        sum4 = {1'b0, b_k} + {1'b0, ~m_k} + {{SLICE{1'b0}}, c4_q};
        c3_n = sum3[SLICE];
        c4_n = sum4[SLICE];
`endif
        // new slice enters at the top; after NSLICE shifts slice 0 sits at bit 0
        s_full = (s_q >> SLICE) | (TOT'(s_k) << (TOT - SLICE));
        t_full = (t_q >> SLICE) | (TOT'(t_k) << (TOT - SLICE));
        if (sub_q) begin
            sel_full = c1_n ? s_full : t_full;
        end else begin
            sel_full = c2_n ? t_full : s_full;
        end
        last = (cnt_q == CW'(NSLICE - 1));
    end

    assign unused_hi = ^sel_full[TOT-1:WIDTH];

    // control: latch on start, step slices in RUN, present result in FIN.
    // The final result is selected on the last RUN edge so FIN is the done
    // cycle itself and can accept the next start back-to-back.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        s_d     = s_q;
        t_d     = t_q;
        sub_d   = sub_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
`ifdef MODADDSUB_RANGECHK_EN
        rerr_d  = rerr_q;
        c3_d    = c3_q;
        c4_d    = c4_q;
`endif
        unique case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = TOT'(in_a);
                    b_d     = TOT'(in_b);
                    m_d     = TOT'(in_m);
                    sub_d   = subtract;
                    c1_d    = subtract;
                    c2_d    = ~subtract;
                    cnt_d   = '0;
`ifdef MODADDSUB_RANGECHK_EN
                    c3_d    = 1'b1;
                    c4_d    = 1'b1;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> SLICE;
                b_d   = b_q >> SLICE;
                m_d   = m_q >> SLICE;
                s_d   = s_full;
                t_d   = t_full;
                c1_d  = c1_n;
                c2_d  = c2_n;
                cnt_d = cnt_q + CW'(1);
`ifdef MODADDSUB_RANGECHK_EN
                c3_d  = c3_n;
                c4_d  = c4_n;
`endif
                if (last) begin
                    res_d   = sel_full[WIDTH-1:0];
`ifdef MODADDSUB_RANGECHK_EN
                    rerr_d  = c3_n | c4_n;
                    if (c3_n | c4_n) begin
                        res_d = '0;
                    end
`endif
                    state_d = FIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            s_q     <= '0;
            t_q     <= '0;
            sub_q   <= 1'b0;
            c1_q    <= 1'b0;
            c2_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
`ifdef MODADDSUB_RANGECHK_EN
            rerr_q  <= 1'b0;
            c3_q    <= 1'b0;
            c4_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            s_q     <= s_d;
            t_q     <= t_d;
            sub_q   <= sub_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
`ifdef MODADDSUB_RANGECHK_EN
            rerr_q  <= rerr_d;
            c3_q    <= c3_d;
            c4_q    <= c4_d;
`endif
        end
    end

    assign result = res_q;
    assign done   = (state_q == FIN);
    assign busy   = (state_q == RUN);
`ifdef MODADDSUB_RANGECHK_EN
    assign range_err = rerr_q;
`else
    assign range_err = 1'b0;
`endif

endmodule
